// File: rtl/soc_addr_decode.sv
// rtl/soc_addr_decode.sv - address decoder routing requests to nine slave regions
module soc_addr_decode #(
    parameter int AddrWidth = 64,
    parameter int IdWidth   = 4,
    parameter int CntWidth  = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 req_valid_i,
    output logic                 req_ready_o,
    input  logic [AddrWidth-1:0] req_addr_i,
    input  logic [IdWidth-1:0]   req_id_i,
    input  logic                 req_write_i,
    output logic                 slv_valid_o,
    input  logic                 slv_ready_i,
    output logic [3:0]           slv_sel_o,
    output logic [AddrWidth-1:0] slv_offset_o,
    output logic [IdWidth-1:0]   slv_id_o,
    output logic                 slv_write_o,
    output logic                 err_valid_o,
    input  logic                 err_ready_i,
    output logic [IdWidth-1:0]   err_id_o,
    output logic                 err_write_o,
    output logic [CntWidth-1:0]  err_cnt_o
);

    typedef enum logic [1:0] {EMPTY, SLV, ERR} state_t;

    state_t state;

    function automatic logic [AddrWidth-1:0] region_base(input int idx);
        case (idx)
            0:       region_base = AddrWidth'(32'h8000_0000);
            1:       region_base = AddrWidth'(32'h4000_0000);
            2:       region_base = AddrWidth'(32'h3000_0000);
            3:       region_base = AddrWidth'(32'h2000_0000);
            4:       region_base = AddrWidth'(32'h1000_0000);
            5:       region_base = AddrWidth'(32'h0C00_0000);
            6:       region_base = AddrWidth'(32'h0200_0000);
            7:       region_base = AddrWidth'(32'h0001_0000);
            default: region_base = '0;
        endcase
    endfunction

    function automatic logic [AddrWidth-1:0] region_len(input int idx);
        case (idx)
            0:       region_len = AddrWidth'(32'h4000_0000);
            1:       region_len = AddrWidth'(32'h0000_1000);
            2:       region_len = AddrWidth'(32'h0001_0000);
            3:       region_len = AddrWidth'(32'h0080_0000);
            4:       region_len = AddrWidth'(32'h0000_1000);
            5:       region_len = AddrWidth'(32'h0400_0000);
            6:       region_len = AddrWidth'(32'h0010_0000);
            7:       region_len = AddrWidth'(32'h0001_0000);
            default: region_len = AddrWidth'(32'h0000_1000);
        endcase
    endfunction

    logic                 dec_hit;
    logic [3:0]           dec_sel;
    logic [AddrWidth-1:0] dec_base;

    // Regions are disjoint, so the first match is the only match.
    always_comb begin
        dec_hit  = 1'b0;
        dec_sel  = '0;
        dec_base = '0;
        for (int i = 0; i < 9; i++) begin
            if (!dec_hit && req_addr_i >= region_base(i) &&
                req_addr_i < region_base(i) + region_len(i)) begin
                dec_hit  = 1'b1;
                dec_sel  = 4'(i);
                dec_base = region_base(i);
            end
        end
    end

    logic out_done;
    logic accept;

    assign out_done    = (state == SLV && slv_ready_i) || (state == ERR && err_ready_i);
    assign req_ready_o = !rst_i && (state == EMPTY || out_done);
    assign accept      = req_valid_i && req_ready_o;
    assign slv_valid_o = (state == SLV);
    assign err_valid_o = (state == ERR);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state        <= EMPTY;
            slv_sel_o    <= '0;
            slv_offset_o <= '0;
            slv_id_o     <= '0;
            slv_write_o  <= 1'b0;
            err_id_o     <= '0;
            err_write_o  <= 1'b0;
            err_cnt_o    <= '0;
        end else begin
            if (accept) begin
                if (dec_hit) begin
                    state        <= SLV;
                    slv_sel_o    <= dec_sel;
                    slv_offset_o <= req_addr_i - dec_base;
                    slv_id_o     <= req_id_i;
                    slv_write_o  <= req_write_i;
                    err_id_o     <= '0;
                    err_write_o  <= 1'b0;
                end else begin
                    state        <= ERR;
                    slv_sel_o    <= '0;
                    slv_offset_o <= '0;
                    slv_id_o     <= '0;
                    slv_write_o  <= 1'b0;
                    err_id_o     <= req_id_i;
                    err_write_o  <= req_write_i;
                end
            end else if (out_done) begin
                state        <= EMPTY;
                slv_sel_o    <= '0;
                slv_offset_o <= '0;
                slv_id_o     <= '0;
                slv_write_o  <= 1'b0;
                err_id_o     <= '0;
                err_write_o  <= 1'b0;
            end
            if (accept && !dec_hit && err_cnt_o != '1) begin
                err_cnt_o <= err_cnt_o + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_soc_addr_decode.sv
// tb/tb_soc_addr_decode.sv - self-checking bench for soc_addr_decode
module tb_soc_addr_decode;

    logic        clk = 0;
    logic        rst, req_valid, req_ready, req_write;
    logic [63:0] req_addr;
    logic [3:0]  req_id;
    logic        slv_valid, slv_ready, slv_write;
    logic [3:0]  slv_sel, slv_id;
    logic [63:0] slv_offset;
    logic        err_valid, err_ready, err_write;
    logic [3:0]  err_id, err_cnt;

    always #5 clk = ~clk;

    soc_addr_decode #(.AddrWidth(64), .IdWidth(4), .CntWidth(4)) dut (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(req_valid), .req_ready_o(req_ready),
        .req_addr_i(req_addr), .req_id_i(req_id), .req_write_i(req_write),
        .slv_valid_o(slv_valid), .slv_ready_i(slv_ready),
        .slv_sel_o(slv_sel), .slv_offset_o(slv_offset), .slv_id_o(slv_id), .slv_write_o(slv_write),
        .err_valid_o(err_valid), .err_ready_i(err_ready),
        .err_id_o(err_id), .err_write_o(err_write), .err_cnt_o(err_cnt)
    );

    int n_pass = 0;
    int n_total = 0;

    // Reference model: the one held output item and the saturating error count.
    logic        m_have, m_err, m_wr;
    logic [3:0]  m_sel, m_id;
    logic [63:0] m_off;
    int          m_cnt;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic void ref_decode(input logic [63:0] a, output logic hit,
                                       output logic [3:0] sel, output logic [63:0] off);
        longint unsigned bases [9] = '{64'h8000_0000, 64'h4000_0000, 64'h3000_0000,
                                       64'h2000_0000, 64'h1000_0000, 64'h0C00_0000,
                                       64'h0200_0000, 64'h0001_0000, 64'h0};
        longint unsigned lens  [9] = '{64'h4000_0000, 64'h1000, 64'h1_0000, 64'h80_0000,
                                       64'h1000, 64'h400_0000, 64'h10_0000, 64'h1_0000, 64'h1000};
        hit = 0; sel = 0; off = 0;
        for (int i = 0; i < 9; i++) begin
            if (a >= bases[i] && (a - bases[i]) < lens[i]) begin
                hit = 1; sel = 4'(i); off = a - bases[i];
            end
        end
    endfunction

    task automatic cycle();
        logic mr, acc, hit;
        logic [3:0]  s;
        logic [63:0] o;
        #1;
        mr = !rst && (!m_have || (m_err ? err_ready : slv_ready));
        check("req_ready", req_ready, mr);
        acc = req_valid && mr;
        ref_decode(req_addr, hit, s, o);
        @(posedge clk);
        if (rst) begin
            m_have = 0; m_cnt = 0;
        end else if (acc) begin
            m_have = 1; m_err = !hit; m_sel = s; m_off = o; m_id = req_id; m_wr = req_write;
            if (!hit && m_cnt < 15) m_cnt++;
        end else if (m_have && (m_err ? err_ready : slv_ready)) begin
            m_have = 0;
        end
        #1;
        check("slv_valid", slv_valid, m_have && !m_err);
        check("err_valid", err_valid, m_have && m_err);
        check("exclusive_valid", slv_valid && err_valid, 0);
        check("slv_sel", slv_sel, (m_have && !m_err) ? m_sel : 0);
        check("slv_offset", slv_offset, (m_have && !m_err) ? m_off : 0);
        check("slv_id", slv_id, (m_have && !m_err) ? m_id : 0);
        check("slv_write", slv_write, m_have && !m_err && m_wr);
        check("err_id", err_id, (m_have && m_err) ? m_id : 0);
        check("err_write", err_write, m_have && m_err && m_wr);
        check("err_cnt", err_cnt, 64'(m_cnt));
    endtask

    task automatic set_req(input logic v, input logic [63:0] a, input logic [3:0] id, input logic w);
        req_valid = v; req_addr = a; req_id = id; req_write = w;
    endtask

    task automatic do_reset();
        rst = 1; set_req(0, 0, 0, 0);
        cycle();
        rst = 0;
    endtask

    typedef struct {
        logic [63:0] addr;
        logic        hit;
        logic [3:0]  sel;
        logic [63:0] off;
        int          cnt;
    } vec_t;

    vec_t vecs [18];

    initial begin
        m_have = 0; m_err = 0; m_wr = 0; m_sel = 0; m_id = 0; m_off = 0; m_cnt = 0;
        slv_ready = 1; err_ready = 1;
        do_reset();
        check("reset_slv_valid", slv_valid, 0);
        check("reset_err_cnt", err_cnt, 0);

        vecs = '{
            '{64'h8000_1234, 1, 0, 64'h1234, 0},
            '{64'h0000_0FFF, 1, 8, 64'hFFF, 0},
            '{64'h0000_1000, 0, 0, 0, 1},
            '{64'hBFFF_FFFF, 1, 0, 64'h3FFF_FFFF, 1},
            '{64'hC000_0000, 0, 0, 0, 2},
            '{64'h4000_0FFF, 1, 1, 64'hFFF, 2},
            '{64'h4000_1000, 0, 0, 0, 3},
            '{64'h3000_FFFF, 1, 2, 64'hFFFF, 3},
            '{64'h2000_0000, 1, 3, 0, 3},
            '{64'h207F_FFFF, 1, 3, 64'h7F_FFFF, 3},
            '{64'h1000_0010, 1, 4, 64'h10, 3},
            '{64'h0C00_0004, 1, 5, 64'h4, 3},
            '{64'h0FFF_FFFF, 1, 5, 64'h3FF_FFFF, 3},
            '{64'h0200_0008, 1, 6, 64'h8, 3},
            '{64'h0001_0000, 1, 7, 0, 3},
            '{64'h1_0000_0000, 0, 0, 0, 4},
            '{64'hFFFF_FFFF_FFFF_FFFF, 0, 0, 0, 5},
            '{64'h8000_0000_8000_0000, 0, 0, 0, 6}
        };
        foreach (vecs[i]) begin
            set_req(1, vecs[i].addr, 4'd3, 1'b0);
            cycle();
            set_req(0, 0, 0, 0);
            check("vec_slv_valid", slv_valid, vecs[i].hit);
            check("vec_err_valid", err_valid, !vecs[i].hit);
            check("vec_sel", slv_sel, vecs[i].sel);
            check("vec_off", slv_offset, vecs[i].off);
            check("vec_id", vecs[i].hit ? slv_id : err_id, 3);
            check("vec_cnt", err_cnt, 64'(vecs[i].cnt));
            cycle();
        end

        // Backpressure on a UART hit while another request waits upstream.
        do_reset();
        slv_ready = 0;
        set_req(1, 64'h1000_0010, 4'd5, 1'b1);
        cycle();
        set_req(1, 64'h0, 4'd1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            check("bp_valid", slv_valid, 1);
            check("bp_sel", slv_sel, 4);
            check("bp_off", slv_offset, 64'h10);
            check("bp_ready", req_ready, 0);
            cycle();
        end
        slv_ready = 1; set_req(0, 0, 0, 0);
        cycle();
        check("bp_drained", slv_valid, 0);

        // Back-to-back alternating CLINT hit and miss.
        do_reset();
        for (int i = 0; i < 8; i++) begin
            set_req(1, (i % 2 == 0) ? 64'h0200_0008 : 64'h5000_0000, 4'(i), 1'b0);
            cycle();
            if (i % 2 == 0) begin
                check("b2b_slv", slv_valid, 1);
                check("b2b_sel", slv_sel, 6);
            end else begin
                check("b2b_err", err_valid, 1);
            end
            check("b2b_cnt", err_cnt, 64'((i + 1) / 2));
        end
        set_req(0, 0, 0, 0);
        cycle();

        // Counter saturation.
        do_reset();
        for (int i = 0; i < 20; i++) begin
            set_req(1, 64'h5000_0000, 4'd0, 1'b0);
            cycle();
        end
        set_req(0, 0, 0, 0);
        cycle();
        check("sat_cnt", err_cnt, 15);

        // Reset while a PLIC hit is stalled.
        do_reset();
        slv_ready = 0;
        set_req(1, 64'h0C00_0004, 4'd2, 1'b0);
        cycle();
        set_req(1, 64'h5000_0000, 4'd2, 1'b0);
        cycle();
        check("stall_valid", slv_valid, 1);
        set_req(0, 0, 0, 0);
        rst = 1;
        cycle();
        rst = 0;
        check("rst_slv_valid", slv_valid, 0);
        check("rst_cnt", err_cnt, 0);
        #1;
        check("rst_ready", req_ready, 1);
        slv_ready = 1;
        cycle();

        // Randomized traffic against the model.
        for (int i = 0; i < 600; i++) begin
            logic [63:0] a;
            int k;
            k = $urandom_range(0, 10);
            case (k)
                0: a = 64'h8000_0000 + 64'($urandom_range(0, 32'h4000_0010)) - 64'h8;
                1: a = 64'h4000_0000 + 64'($urandom_range(0, 32'h1010));
                2: a = 64'h3000_0000 + 64'($urandom_range(0, 32'h1_0010));
                3: a = 64'h2000_0000 + 64'($urandom_range(0, 32'h80_0010));
                4: a = 64'h1000_0000 + 64'($urandom_range(0, 32'h1010)) - 64'h8;
                5: a = 64'h0C00_0000 + 64'($urandom_range(0, 32'h400_0010));
                6: a = 64'h0200_0000 + 64'($urandom_range(0, 32'h10_0010));
                7: a = 64'h0001_0000 + 64'($urandom_range(0, 32'h1_0010)) - 64'h8;
                8: a = 64'($urandom_range(0, 32'h1010));
                default: a = {32'($urandom_range(0, 1)) * $urandom, $urandom};
            endcase
            set_req($urandom_range(0, 3) != 0, a, 4'($urandom), 1'($urandom));
            slv_ready = $urandom_range(0, 9) < 7;
            err_ready = $urandom_range(0, 9) < 7;
            rst = $urandom_range(0, 99) == 0;
            cycle();
        end
        rst = 0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
